// File: rtl/user_proj_gpio_pkg.sv
// rtl/user_proj_gpio_pkg.sv - shared register map, ID constant and irq indices
//
// Purpose: constants shared by the GPIO Wishbone block and its bench.
//   Register offsets are word offsets (wbs_adr_i[7:2]).
package user_proj_gpio_pkg;

  localparam logic [5:0] OFF_OUT       = 6'h00;  // 0x00
  localparam logic [5:0] OFF_OEB       = 6'h01;  // 0x04
  localparam logic [5:0] OFF_IN        = 6'h02;  // 0x08
  localparam logic [5:0] OFF_RISE_EN   = 6'h03;  // 0x0C
  localparam logic [5:0] OFF_FALL_EN   = 6'h04;  // 0x10
  localparam logic [5:0] OFF_RISE_PEND = 6'h05;  // 0x14
  localparam logic [5:0] OFF_FALL_PEND = 6'h06;  // 0x18
  localparam logic [5:0] OFF_ID        = 6'h07;  // 0x1C

  localparam logic [15:0] ID_MAGIC = 16'h6770;

  localparam int IRQ_RISE = 0;
  localparam int IRQ_FALL = 1;
  localparam int IRQ_ANY  = 2;

  // Expand the four byte enables into a 32-bit per-bit write mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad synchroniser with rise/fall edge detect
//
// Purpose: two-flop synchroniser followed by a history flop per channel.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_pad   [W-1:0]   asynchronous pad inputs
//   o_sync  [W-1:0]   synchronised level (second flop)
//   o_rise  [W-1:0]   synchronised level went 0->1 this cycle
//   o_fall  [W-1:0]   synchronised level went 1->0 this cycle
module gpio_sync_edge #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_pad,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_hist;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_hist <= '0;
    end else begin
      r_s1   <= i_pad;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_hist;
  assign o_fall = ~r_s2 & r_hist;

endmodule

// File: rtl/user_proj_gpio_wb.sv
// rtl/user_proj_gpio_wb.sv - Wishbone GPIO block with edge interrupts
//
// Purpose: NCH-channel GPIO with output, output-enable, synchronised input,
//   per-channel rise/fall detection into sticky W1C pending registers and
//   three registered interrupt lines.
// Ports:
//   wb_clk_i, wb_rst_ni            clock, synchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i   Wishbone classic slave request
//   wbs_ack_o, wbs_dat_o           registered acknowledge and read data
//   io_in                          asynchronous pad inputs
//   io_out, io_oeb                 pad drive value and output-enable-bar
//   irq[2:0]                       rise-any, fall-any, either
module user_proj_gpio_wb
  import user_proj_gpio_pkg::*;
#(
  parameter int          NCH      = 20,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic [NCH-1:0] io_in,
  output logic [NCH-1:0] io_out,
  output logic [NCH-1:0] io_oeb,
  output logic [2:0]     irq
);

  localparam logic [7:0] NCH_B = 8'(NCH);

  logic           r_ack;
  logic [31:0]    r_dat;
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_oeb;
  logic [NCH-1:0] r_rise_en;
  logic [NCH-1:0] r_fall_en;
  logic [NCH-1:0] r_rise_pend;
  logic [NCH-1:0] r_fall_pend;
  logic [2:0]     r_irq;

  logic [NCH-1:0] w_sync;
  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_fall;
  logic           w_req;
  logic           w_hit;
  logic           w_wr;
  logic [5:0]     w_off;
  logic [NCH-1:0] w_bmask;
  logic [NCH-1:0] w_wbits;
  logic [NCH-1:0] w_rise_clr;
  logic [NCH-1:0] w_fall_clr;
  logic [31:0]    w_rd;
  logic [31:0]    w_sel_mask;
  logic           w_unused;

  gpio_sync_edge #(.W(NCH)) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_pad   (io_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The ack flop masks the request in the ack cycle, so a held stb gives
  // one ack every second cycle.
  assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_hit      = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_wr       = w_req & w_hit & wbs_we_i;
  assign w_off      = wbs_adr_i[7:2];
  assign w_sel_mask = sel_to_mask(wbs_sel_i);
  assign w_bmask    = w_sel_mask[NCH-1:0];
  assign w_wbits    = wbs_dat_i[NCH-1:0] & w_bmask;
  assign w_rise_clr = (w_wr && w_off == OFF_RISE_PEND) ? w_wbits : '0;
  assign w_fall_clr = (w_wr && w_off == OFF_FALL_PEND) ? w_wbits : '0;

  // Bits at NCH and above, address bits [1:0] and the upper byte-mask bits
  // have no storage behind them.
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_sel_mask};

  always_comb begin
    w_rd = '0;
    case (w_off)
      OFF_OUT:       w_rd[NCH-1:0] = r_out;
      OFF_OEB:       w_rd[NCH-1:0] = r_oeb;
      OFF_IN:        w_rd[NCH-1:0] = w_sync;
      OFF_RISE_EN:   w_rd[NCH-1:0] = r_rise_en;
      OFF_FALL_EN:   w_rd[NCH-1:0] = r_fall_en;
      OFF_RISE_PEND: w_rd[NCH-1:0] = r_rise_pend;
      OFF_FALL_PEND: w_rd[NCH-1:0] = r_fall_pend;
      OFF_ID:        w_rd = {ID_MAGIC, 8'd0, NCH_B};
      default:       w_rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_out       <= '0;
      r_oeb       <= '1;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_rise_pend <= '0;
      r_fall_pend <= '0;
      r_irq       <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && w_hit && !wbs_we_i) ? w_rd : '0;
      if (w_wr) begin
        case (w_off)
          OFF_OUT:     r_out     <= (r_out     & ~w_bmask) | w_wbits;
          OFF_OEB:     r_oeb     <= (r_oeb     & ~w_bmask) | w_wbits;
          OFF_RISE_EN: r_rise_en <= (r_rise_en & ~w_bmask) | w_wbits;
          OFF_FALL_EN: r_fall_en <= (r_fall_en & ~w_bmask) | w_wbits;
          default: ;
        endcase
      end
      // Set wins over a simultaneous W1C on the same bit.
      r_rise_pend <= (r_rise_pend & ~w_rise_clr) | (w_rise & r_rise_en);
      r_fall_pend <= (r_fall_pend & ~w_fall_clr) | (w_fall & r_fall_en);
      r_irq[IRQ_RISE] <= |r_rise_pend;
      r_irq[IRQ_FALL] <= |r_fall_pend;
      r_irq[IRQ_ANY]  <= (|r_rise_pend) | (|r_fall_pend);
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out;
  assign io_oeb    = r_oeb;
  assign irq       = r_irq;

endmodule

// File: tb/tb_user_proj_gpio_wb.sv
// tb/tb_user_proj_gpio_wb.sv - directed self-checking bench for user_proj_gpio_wb
module tb_user_proj_gpio_wb;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_OUT = BASE + 32'h00, A_OEB = BASE + 32'h04, A_IN = BASE + 32'h08;
  localparam logic [31:0] A_REN = BASE + 32'h0C, A_FEN = BASE + 32'h10;
  localparam logic [31:0] A_RP  = BASE + 32'h14, A_FP  = BASE + 32'h18, A_ID = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [19:0] io_in = '0;
  logic [19:0] io_out, io_oeb;
  logic [2:0]  irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  user_proj_gpio_wb dut (
    .wb_clk_i (clk),     .wb_rst_ni (rstn),
    .wbs_cyc_i(cyc),     .wbs_stb_i (stb),   .wbs_we_i (we),
    .wbs_sel_i(sel),     .wbs_adr_i (adr),   .wbs_dat_i(wdat),
    .wbs_ack_o(ack),     .wbs_dat_o (rdat_o),
    .io_in    (io_in),   .io_out    (io_out), .io_oeb  (io_oeb),
    .irq      (irq)
  );

  // Bus driver: lat is the number of cycles to ack, -1 if none within 4.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = -1; rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (ack) begin lat = i; rd = rdat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, a, d, s, rd, lat);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] rd; int lat;
    wait_cyc(3);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0 || rdat_o !== 32'h0) begin errors++; $display("FAIL reset_bus: ack=%b dat=%h expected 0/0", ack, rdat_o); end
    checks++; if (io_out !== 20'h0 || io_oeb !== 20'hFFFFF) begin errors++; $display("FAIL reset_pads: out=%h oeb=%h expected 00000/fffff", io_out, io_oeb); end
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL reset_irq: got %b expected 000", irq); end
    wb_xfer(1'b0, A_REN, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rise_en: got %h expected 0", rd); end
  endtask

  task automatic test_out;
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, A_OUT, 32'h000A_5A5A, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL out_ack_latency: got %0d expected 1", lat); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL out_ack_width: ack still %b expected 0", ack); end
    checks++; if (io_out !== 20'hA5A5A) begin errors++; $display("FAIL out_pad: got %h expected a5a5a", io_out); end
    wb_xfer(1'b0, A_OUT, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h000A_5A5A || lat !== 1) begin errors++; $display("FAIL out_readback: got %h lat %0d expected 000a5a5a lat 1", rd, lat); end
    wb_wr(A_OUT, 32'hFFFF_FFFF, 4'b0100);
    wb_xfer(1'b0, A_OUT, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h000F_5A5A) begin errors++; $display("FAIL out_lane2_mask: got %h expected 000f5a5a", rd); end
  endtask

  task automatic test_oeb;
    logic [31:0] rd; int lat;
    wb_wr(A_OEB, 32'hFFFF_0000, 4'b1100);
    wb_xfer(1'b0, A_OEB, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h000F_FFFF) begin errors++; $display("FAIL oeb_upper_lanes: got %h expected 000fffff", rd); end
    wb_wr(A_OEB, 32'hFFFF_0000, 4'b0011);
    wb_xfer(1'b0, A_OEB, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h000F_0000) begin errors++; $display("FAIL oeb_lower_lanes: got %h expected 000f0000", rd); end
    checks++; if (io_oeb !== 20'hF0000) begin errors++; $display("FAIL oeb_pad: got %h expected f0000", io_oeb); end
  endtask

  task automatic test_id_in;
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, A_ID, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h6770_0014) begin errors++; $display("FAIL id: got %h expected 67700014", rd); end
    io_in = 20'h12345;
    wait_cyc(4);
    wb_xfer(1'b0, A_IN, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0001_2345) begin errors++; $display("FAIL in_read: got %h expected 00012345", rd); end
    io_in = 20'h0;
    wait_cyc(4);
    wb_xfer(1'b0, A_RP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL no_pend_when_disabled: got %h expected 0", rd); end
  endtask

  task automatic test_unmapped;
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, BASE + 32'h100, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL nonhit_read: got %h lat %0d expected 0 lat 1", rd, lat); end
    wb_xfer(1'b0, BASE + 32'h20, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL unmapped_read: got %h lat %0d expected 0 lat 1", rd, lat); end
    wb_xfer(1'b1, 32'h3100_0000, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nonhit_write_ack: lat %0d expected 1", lat); end
    wb_xfer(1'b0, A_OUT, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h000F_5A5A) begin errors++; $display("FAIL nonhit_write_discard: OUT %h expected 000f5a5a", rd); end
  endtask

  task automatic test_back_to_back;
    int n_ack = 0, n_good = 0, n_bad_idle = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_ID; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) begin n_ack++; if (rdat_o === 32'h6770_0014) n_good++; end
      else if (rdat_o !== 32'h0) n_bad_idle++;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++; if (n_ack !== 3) begin errors++; $display("FAIL held_stb_acks: got %0d expected 3", n_ack); end
    checks++; if (n_good !== 3) begin errors++; $display("FAIL held_stb_data: good %0d expected 3", n_good); end
    checks++; if (n_bad_idle !== 0) begin errors++; $display("FAIL idle_dat_zero: nonzero idle cycles %0d expected 0", n_bad_idle); end
    @(negedge clk);
  endtask

  task automatic test_rise_irq;
    logic [31:0] rd; int lat;
    wb_wr(A_REN, 32'h1, 4'hF);
    io_in = 20'h00001;
    wait_cyc(3);
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL rise_irq_early: got %b expected 000", irq); end
    wait_cyc(1);
    checks++; if (irq !== 3'b101) begin errors++; $display("FAIL rise_irq: got %b expected 101", irq); end
    wb_xfer(1'b0, A_RP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rise_pend: got %h expected 1", rd); end
    wb_wr(A_RP, 32'h1, 4'hF);
    checks++; if (irq !== 3'b101) begin errors++; $display("FAIL rise_irq_hold: got %b expected 101", irq); end
    @(negedge clk);
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL rise_irq_clear: got %b expected 000", irq); end
  endtask

  task automatic test_fall_collision;
    logic [31:0] rd; int lat;
    wb_wr(A_FEN, 32'h8, 4'hF);
    io_in = 20'h00009; wait_cyc(5);
    io_in = 20'h00001; wait_cyc(5);
    checks++; if (irq !== 3'b110) begin errors++; $display("FAIL fall_irq: got %b expected 110", irq); end
    wb_wr(A_FP, 32'h8, 4'hF);
    wb_xfer(1'b0, A_FP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fall_w1c: got %h expected 0", rd); end
    io_in = 20'h00009; wait_cyc(5);
    io_in = 20'h00001;
    wait_cyc(2);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_FP; wdat = 32'h8; sel = 4'hF;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL collision_ack: got %b expected 1", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_xfer(1'b0, A_FP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL set_priority: got %h expected 8", rd); end
    wb_wr(A_FP, 32'h8, 4'hF);
  endtask

  task automatic test_sticky;
    logic [31:0] rd; int lat;
    wb_wr(A_REN, 32'h3, 4'hF);
    io_in = 20'h00003; wait_cyc(5);
    wb_wr(A_REN, 32'h0, 4'hF);
    wait_cyc(2);
    wb_xfer(1'b0, A_RP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL sticky_pend: got %h expected 2", rd); end
    checks++; if (irq !== 3'b101) begin errors++; $display("FAIL sticky_irq: got %b expected 101", irq); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; int lat;
    int n_ack = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_OUT; wdat = 32'h000F_FFFF; sel = 4'hF;
    rstn = 1'b0;
    @(negedge clk);
    if (ack) n_ack++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    if (ack) n_ack++;
    rstn = 1'b1;
    @(negedge clk);
    if (ack) n_ack++;
    checks++; if (n_ack !== 0) begin errors++; $display("FAIL abort_no_ack: acks %0d expected 0", n_ack); end
    checks++; if (io_out !== 20'h0 || io_oeb !== 20'hFFFFF) begin errors++; $display("FAIL abort_pads: out=%h oeb=%h expected 00000/fffff", io_out, io_oeb); end
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL abort_irq: got %b expected 000", irq); end
    wait_cyc(5);
    wb_xfer(1'b0, A_RP, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_pend: got %h expected 0", rd); end
    wb_xfer(1'b0, A_OUT, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_discard: OUT %h expected 0", rd); end
  endtask

  initial begin
    test_reset;
    test_out;
    test_oeb;
    test_id_in;
    test_unmapped;
    test_back_to_back;
    test_rise_irq;
    test_fall_collision;
    test_sticky;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
